matmul_sp_module: RTL
=====================

// Module: matmul_sp_module
// PURPOSE
//  Result scratchpad at the receiving end of the matmul result interface.
//  - Captures a full C matrix plus its overflow flags in one cycle on enable_w_i.
//  - Returns a stored matrix combinationally as c_bias_o (bias path) and
//    as a registered BUS_WIDTH-wide burst with ready/valid flow control (bus read path).
// PARAMETERS
//  DATA_WIDTH   8   element width of A/B; each C element is 2*DATA_WIDTH
//  BUS_WIDTH    16  read-bus word width; MAX_DIM = BUS_WIDTH/DATA_WIDTH
//  SP_NTARGETS  4   number of stored matrices (power of 2, >=2); TW = log2(SP_NTARGETS)
//  Derived: CW = MAX_DIM*MAX_DIM*2*DATA_WIDTH; FW = MAX_DIM*MAX_DIM; BEATS = CW/BUS_WIDTH
// PORTS
//  clk_i           in   1      clock, rising edge
//  rst_ni          in   1      asynchronous reset, active low
//  enable_w_i      in   1      write strobe, one cycle per result
//  write_target_i  in   TW     slot written on enable_w_i
//  c_matrix_i      in   CW     signed result matrix, element j at [(j+1)*2*DATA_WIDTH-1 : j*2*DATA_WIDTH]
//  flags_i         in   FW     overflow flags stored with c_matrix_i
//  bias_target_i   in   TW     slot driven onto c_bias_o
//  c_bias_o        out  CW     mem[bias_target_i], combinational
//  rd_start_i      in   1      request a burst read of rd_target_i
//  rd_target_i     in   TW     slot to read
//  rd_ready_i      in   1      consumer accepts the current beat
//  rd_data_o       out  BUS    current beat
//  rd_valid_o      out  1      rd_data_o is valid
//  rd_last_o       out  1      current beat is beat BEATS-1
//  rd_flags_o      out  FW     flags of the slot being read, held for the whole burst
//  busy_o          out  1      burst in progress (rd_start_i is ignored)
//  valid_o         out  SP_NTARGETS  slot written since reset
// BEHAVIOUR
//  Reset (async, rst_ni=0):
//  - All slots, flags and valid_o clear to 0; FSM goes to IDLE.
//  - rd_data_o, rd_valid_o, rd_last_o, rd_flags_o and busy_o are 0.
//  - A burst in progress is aborted; no further beats are driven after reset.
//  Write:
//  - On a rising edge with enable_w_i=1, mem[write_target_i] <= c_matrix_i,
//    flag_mem[write_target_i] <= flags_i, and valid_o[write_target_i] <= 1.
//  - New data is visible on c_bias_o from the next cycle.
//  - A write is accepted every cycle; there is no backpressure.
//  Bias path: c_bias_o = mem[bias_target_i]; no latency and no FSM involvement.
//  Read FSM:
//  - IDLE: rd_start_i=1 -> snapshot mem[rd_target_i] and flag_mem[rd_target_i]
//    into shadow regs; beat=0; go to READ.
//  - READ: busy_o=1, rd_valid_o=1, rd_data_o = shadow[(beat+1)*BUS_WIDTH-1 : beat*BUS_WIDTH],
//    rd_last_o = (beat==BEATS-1).
//  - READ: rd_ready_i=1 with last=0 -> beat++. rd_ready_i=1 with last=1 -> IDLE,
//    and rd_valid_o drops in the next cycle. rd_ready_i=0 -> hold all outputs stable.
//  - First beat is valid in the cycle after rd_start_i is sampled (latency 1).
//  - Outputs are registered; beat order is least-significant word first.
//  Boundary cases:
//  - Write and rd_start_i in the same cycle to the same slot: the snapshot takes
//    the OLD data, and the write still completes.
//  - A write to the slot under read during a burst does not affect the burst,
//    because the burst reads the shadow regs.
//  - rd_start_i while busy_o=1 is dropped and is not queued.
//  - Back-to-back bursts are allowed: a start in the first IDLE cycle after the last beat is accepted.
//  - Reading a slot with valid_o=0 is legal and returns the stored zeros; the
//    consumer checks valid_o.
//  - Data is stored raw: no sign extension, saturation or clearing of flags.
// STRUCTURE
//  Shared package matmul_pkg:
//  - MAX_DIM, CW, FW, BEATS derivation functions.
//  - State encoding: IDLE=1'b0, READ=1'b1.
//  - clog2 helper for TW and the beat counter.
//  Sub-module matmul_sp_read_fsm: shadow regs, beat counter and handshake.
//  The top level holds the storage array, the write port and the bias mux.
// TESTING
//  1. Reset: rst_ni=0 mid-burst (beat 2) -> next cycle all outputs 0 and valid_o=0;
//     a later read of slot 0 streams 4 beats of 16'h0000.
//  2. Write then bias: write slot 2, C=64'h0004_0003_0002_0001, flags=4'b0010 ->
//     c_bias_o shows that C one cycle later when bias_target_i=2, and valid_o=4'b0100.
//  3. Burst, rd_ready_i=1: read slot 2 -> beats 0001,0002,0003,0004, rd_last_o only
//     on 0004, rd_flags_o=4'b0010, busy_o high for exactly 4 cycles.
//  4. Backpressure: rd_ready_i low on beat 1 for 3 cycles -> rd_data_o holds 16'h0002
//     with rd_valid_o=1; the burst completes in 7 cycles.
//  5. Collision: during a burst on slot 2, write slot 2 = 64'hFFFF_FFFF_FFFF_FFFF and
//     assert rd_start_i -> the burst still returns 0001..0004 and the start is ignored;
//     the next read returns FFFF x4.
//  6. Same-cycle write and start on slot 1 (old 64'h1111_..., new 64'h2222_...) ->
//     the burst returns 1111 x4, and c_bias_o(slot 1) = 2222... on the next cycle.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared definitions for the matmul result scratchpad.
// Geometry derivation, read FSM state encoding and a clog2 helper.
package matmul_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } rd_state_e;

    // Never returns 0, so it can size single-entry counters too.
    function automatic int clog2_f(input int n);
        int r;
        for (r = 1; (1 << r) < n; r++) begin
        end
        return r;
    endfunction

    function automatic int max_dim_f(input int dw, input int bw);
        return bw / dw;
    endfunction

    function automatic int cw_f(input int dw, input int bw);
        return max_dim_f(dw, bw) * max_dim_f(dw, bw) * 2 * dw;
    endfunction

    function automatic int fw_f(input int dw, input int bw);
        return max_dim_f(dw, bw) * max_dim_f(dw, bw);
    endfunction

    function automatic int beats_f(input int dw, input int bw);
        return cw_f(dw, bw) / bw;
    endfunction

endpackage

// File: rtl/matmul_sp_read_fsm.sv
// Burst reader: snapshots one slot into shadow regs and streams it
// out LS word first with ready/valid flow control.
module matmul_sp_read_fsm
    import matmul_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int BUS_WIDTH  = 16,
    localparam int CW    = cw_f(DATA_WIDTH, BUS_WIDTH),
    localparam int FW    = fw_f(DATA_WIDTH, BUS_WIDTH),
    localparam int BEATS = beats_f(DATA_WIDTH, BUS_WIDTH)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 rd_start_i,
    input  logic [CW-1:0]        snap_data_i,
    input  logic [FW-1:0]        snap_flags_i,
    input  logic                 rd_ready_i,
    output logic [BUS_WIDTH-1:0] rd_data_o,
    output logic                 rd_valid_o,
    output logic                 rd_last_o,
    output logic [FW-1:0]        rd_flags_o,
    output logic                 busy_o
);

    localparam int BCW = clog2_f(BEATS);
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);

    rd_state_e      state;
    logic [CW-1:0]  shadow;
    logic [BCW-1:0] beat;
    logic [BCW-1:0] beat_nx;

    assign beat_nx = beat + 1'b1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            shadow     <= '0;
            beat       <= '0;
            rd_data_o  <= '0;
            rd_valid_o <= 1'b0;
            rd_last_o  <= 1'b0;
            rd_flags_o <= '0;
            busy_o     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (rd_start_i) begin
                        state      <= READ;
                        shadow     <= snap_data_i;
                        rd_flags_o <= snap_flags_i;
                        beat       <= '0;
                        rd_data_o  <= snap_data_i[BUS_WIDTH-1:0];
                        rd_valid_o <= 1'b1;
                        rd_last_o  <= (LAST_BEAT == '0);
                        busy_o     <= 1'b1;
                    end
                end
                READ: begin
                    if (rd_ready_i) begin
                        if (rd_last_o) begin
                            state      <= IDLE;
                            rd_data_o  <= '0;
                            rd_valid_o <= 1'b0;
                            rd_last_o  <= 1'b0;
                            busy_o     <= 1'b0;
                        end else begin
                            beat      <= beat_nx;
                            rd_data_o <= shadow[int'(beat_nx) * BUS_WIDTH +: BUS_WIDTH];
                            rd_last_o <= (beat_nx == LAST_BEAT);
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/matmul_sp_module.sv
// Result scratchpad: slot storage, single-cycle write port,
// combinational bias mux and a burst read port.
module matmul_sp_module
    import matmul_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int BUS_WIDTH   = 16,
    parameter int SP_NTARGETS = 4,
    localparam int CW = cw_f(DATA_WIDTH, BUS_WIDTH),
    localparam int FW = fw_f(DATA_WIDTH, BUS_WIDTH),
    localparam int TW = clog2_f(SP_NTARGETS)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   enable_w_i,
    input  logic [TW-1:0]          write_target_i,
    input  logic [CW-1:0]          c_matrix_i,
    input  logic [FW-1:0]          flags_i,
    input  logic [TW-1:0]          bias_target_i,
    output logic [CW-1:0]          c_bias_o,
    input  logic                   rd_start_i,
    input  logic [TW-1:0]          rd_target_i,
    input  logic                   rd_ready_i,
    output logic [BUS_WIDTH-1:0]   rd_data_o,
    output logic                   rd_valid_o,
    output logic                   rd_last_o,
    output logic [FW-1:0]          rd_flags_o,
    output logic                   busy_o,
    output logic [SP_NTARGETS-1:0] valid_o
);

    logic [CW-1:0] mem      [SP_NTARGETS];
    logic [FW-1:0] flag_mem [SP_NTARGETS];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < SP_NTARGETS; i++) begin
                mem[i]      <= '0;
                flag_mem[i] <= '0;
            end
            valid_o <= '0;
        end else if (enable_w_i) begin
            mem[write_target_i]      <= c_matrix_i;
            flag_mem[write_target_i] <= flags_i;
            valid_o[write_target_i]  <= 1'b1;
        end
    end

    assign c_bias_o = mem[bias_target_i];

    // Snapshot sees pre-write contents, so a same-cycle write lands after it.
    matmul_sp_read_fsm #(
        .DATA_WIDTH (DATA_WIDTH),
        .BUS_WIDTH  (BUS_WIDTH)
    ) u_read_fsm (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .rd_start_i   (rd_start_i),
        .snap_data_i  (mem[rd_target_i]),
        .snap_flags_i (flag_mem[rd_target_i]),
        .rd_ready_i   (rd_ready_i),
        .rd_data_o    (rd_data_o),
        .rd_valid_o   (rd_valid_o),
        .rd_last_o    (rd_last_o),
        .rd_flags_o   (rd_flags_o),
        .busy_o       (busy_o)
    );

endmodule
